// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decoder and redirect signals of the fetch stage
interface fetch_unit_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [5:0]        inst_opcode;
    logic [5:0]        inst_func;
    logic [ADDR_W-1:0] inst_pc_plus4;
    logic              jump_en;
    logic [25:0]       jump_index;
    logic              branch_en;
    logic [15:0]       branch_offset;
    logic [ADDR_W-1:0] redirect_base;
    logic              halt;
    logic              halted;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_opcode, inst_func, inst_pc_plus4, halted,
        input  imem_valid, imem_rdata, inst_ready, jump_en, jump_index, branch_en, branch_offset,
               redirect_base, halt
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_opcode, inst_func, inst_pc_plus4, halted,
        output imem_valid, imem_rdata, inst_ready, jump_en, jump_index, branch_en, branch_offset,
               redirect_base, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect squash and sticky halt
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst_b,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {START, FETCH, WAIT, HOLD, HALTED} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, target, pc_plus4_q;
    logic [31:0]       inst_q;
    logic              squash, squash_nx, redirect, capture;
    assign redirect = bus.jump_en | bus.branch_en;
    assign target   = bus.jump_en ? {bus.redirect_base[ADDR_W-1:28], bus.jump_index, 2'b00}
                    : bus.redirect_base + {{(ADDR_W-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        squash_nx = squash;
        capture   = 1'b0;
        case (state)
            START: state_nx = FETCH;
            FETCH: state_nx = WAIT;
            WAIT: if (bus.imem_valid) begin
                state_nx  = (squash || redirect) ? FETCH : HOLD;
                capture   = !squash && !redirect;
                squash_nx = 1'b0;
            end
            HOLD: if (redirect || bus.inst_ready) state_nx = FETCH;
            default: ;
        endcase
        // a redirect coinciding with the response drops that word directly, no squash needed
        if (redirect && state != HALTED) begin
            pc_nx = target;
            if (state == FETCH || (state == WAIT && !bus.imem_valid)) squash_nx = 1'b1;
        end else if (state == HOLD && bus.inst_ready) pc_nx = pc + ADDR_W'(4);
        if (bus.halt) begin
            state_nx  = HALTED;
            pc_nx     = pc;
            squash_nx = squash;
            capture   = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= START;
            pc         <= RESET_PC;
            squash     <= 1'b0;
            inst_q     <= '0;
            pc_plus4_q <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            squash <= squash_nx;
            if (capture) begin
                inst_q     <= bus.imem_rdata;
                pc_plus4_q <= pc + ADDR_W'(4);
            end
        end
    end
    assign bus.imem_req      = state == FETCH;
    assign bus.imem_addr     = pc;
    assign bus.inst_valid    = state == HOLD;
    assign bus.inst          = inst_q;
    assign bus.inst_opcode   = inst_q[31:26];
    assign bus.inst_func     = inst_q[5:0];
    assign bus.inst_pc_plus4 = pc_plus4_q;
    assign bus.halted        = state == HALTED;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control decoder. It holds the PC and issues one word request at a time to instruction memory. It presents the fetched word, with opcode [31:26] and func [5:0] split out, to the decoder through a valid/ready handshake. It accepts jump and branch redirects and halt from downstream; redirects squash any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
ADDR_W, 32, PC and memory address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_b  in  1  reset, asynchronous and active-low
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  ADDR_W  word address of request, bits [1:0] always 0
imem_valid  in  1  response strobe, any latency of 1 or more cycles after imem_req
imem_rdata  in  32  instruction word, valid with imem_valid
inst_valid  out  1  instruction presented to the decoder
inst_ready  in  1  decoder accepts the instruction
inst  out  32  held instruction word
inst_opcode  out  6  inst[31:26]
inst_func  out  6  inst[5:0]
inst_pc_plus4  out  ADDR_W  PC of held instruction + 4
jump_en  in  1  jump redirect, one-cycle strobe
jump_index  in  26  J-type target field
branch_en  in  1  taken-branch redirect, one-cycle strobe
branch_offset  in  16  I-type immediate
redirect_base  in  ADDR_W  pc_plus4 of the redirecting instruction
halt  in  1  halt request from the decoder
halted  out  1  fetch stopped, sticky until reset

Behaviour:
- Reset (rst_b=0, async):
  - pc=RESET_PC; state=START; squash=0.
  - Outputs: imem_req=0, inst_valid=0, inst=0, inst_pc_plus4=0, halted=0.
  - imem_addr=pc.
- FSM states: START, FETCH, WAIT, HOLD, HALTED.
- START: one idle cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1 for exactly this cycle; imem_addr=pc.
  - Next state WAIT.
- WAIT:
  - imem_req=0.
  - On imem_valid with squash=1: discard the word, clear squash, go to FETCH using the already-redirected pc.
  - On imem_valid with squash=0: latch inst=imem_rdata and inst_pc_plus4=pc+4, go to HOLD.
- HOLD:
  - inst_valid=1; inst, opcode, func and inst_pc_plus4 stay stable until accepted.
  - Handshake completes in a cycle with inst_valid & inst_ready.
  - On completion: pc=pc+4 (wraps modulo 2^ADDR_W), inst_valid drops next cycle, go to FETCH.
  - Fetch-to-present latency: FETCH -> imem_valid (N cycles) -> inst_valid 1 cycle later.
- Redirect target (registered):
  - jump_en: {redirect_base[31:28], jump_index, 2'b00}.
  - branch_en: redirect_base + (sext(branch_offset) << 2), 32-bit wrap.
  - Both asserted: jump wins.
- Redirect in any non-HALTED state: pc=target.
  - FETCH or WAIT: set squash so the outstanding response is discarded.
  - HOLD: inst_valid deasserts next cycle, go to FETCH. The redirect wins over a same-cycle inst_ready; that handshake does not advance pc.
  - START: pc=target, normal START->FETCH.
- Halt:
  - When halt=1, go to HALTED next cycle regardless of other inputs; halt has top priority over redirect and handshake.
  - HALTED: halted=1, imem_req=0, inst_valid=0; pc frozen.
  - A late imem_valid in HALTED is ignored.
  - Only rst_b exits HALTED.
- Reset mid-operation: immediate return to reset values; a pending memory response after reset is ignored unless state=WAIT, which cannot occur before START->FETCH completes.
- Never more than one outstanding request.

Test Plan:
- Reset with RESET_PC=0x0, memory latency 1, inst_ready=1 -> requests at addr 0x0, 0x4, 0x8; inst 0x00851020 shows opcode=0, func=0x20, inst_pc_plus4=0x4.
- HOLD with inst_ready=0 for 5 cycles -> inst_valid and inst stable, no imem_req, pc unchanged; then ready -> next req at pc+4.
- branch_en with redirect_base=0x100, offset=0xFFFE while in WAIT (latency 3) -> returning word discarded; next imem_addr=0xF8; inst_valid stays 0 until the 0xF8 word returns.
- jump_en and branch_en together, redirect_base=0x40000010, jump_index=0x0000040 -> next imem_addr=0x40000100.
- halt=1 together with inst_ready and jump_en in HOLD -> halted=1 next cycle, no further imem_req, pc frozen; rst_b pulse -> halted=0, fetch restarts at RESET_PC.
- rst_b asserted during WAIT, response arrives 1 cycle after release -> response ignored; first new request at RESET_PC after START.
